// File: rtl/cpu_periph_pkg.sv
// Shared types for the CPU/peripheral four-phase handshake link: data width
// default and the state encodings of both FSMs.
package cpu_periph_pkg;

  localparam int DATA_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    C_PREP = 2'd0,
    C_SEND = 2'd1,
    C_WAIT = 2'd2
  } cpu_state_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_ACK  = 2'd1
  } periph_state_e;

endpackage

// File: rtl/periph_rx.sv
// Peripheral side of the four-phase handshake: acknowledges each send strobe
// and captures the offered data word on the P_IDLE->P_ACK edge.
module periph_rx
  import cpu_periph_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_in,
  input  logic [DATA_W-1:0] dados_in,
  output logic              ack,
  output logic [1:0]        estadoPeriferico,
  output logic [DATA_W-1:0] dadosPeriferico
);

  periph_state_e     state_r;
  periph_state_e     state_s;
  logic              capture_s;
  logic              ack_r;
  logic [DATA_W-1:0] data_r;

  // Next-state and capture decision from the observed send strobe
  always_comb begin
    state_s   = P_IDLE;
    capture_s = 1'b0;
    case (state_r)
      P_IDLE: begin
        if (send_in) begin
          state_s   = P_ACK;
          capture_s = 1'b1;
        end else begin
          state_s = P_IDLE;
        end
      end
      P_ACK: begin
        if (send_in) begin
          state_s = P_ACK;
        end else begin
          state_s = P_IDLE;
        end
      end
      default: state_s = P_IDLE;
    endcase
  end

  // State, acknowledge and captured-data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= P_IDLE;
      ack_r   <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      ack_r   <= (state_s == P_ACK);
      if (capture_s) begin
        data_r <= dados_in;
      end
    end
  end

  assign ack              = ack_r;
  assign estadoPeriferico = state_r;
  assign dadosPeriferico  = data_r;

endmodule

// File: rtl/cpu_periph_link.sv
// CPU side of the link plus the peripheral instance. Define LINK_SYNC_EN to
// route send/ack through 2-flop synchronizers (13-clock transfer vs 5).
module cpu_periph_link
  import cpu_periph_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [1:0]        estadoCPU,
  output logic [1:0]        estadoPeriferico,
  output logic [DATA_W-1:0] dados,
  output logic              send,
  output logic              ack,
  output logic [DATA_W-1:0] dadosPeriferico
);

  cpu_state_e        cpu_state_r;
  cpu_state_e        cpu_state_s;
  logic [DATA_W-1:0] dados_r;
  logic [DATA_W-1:0] dados_s;
  logic              send_r;
  logic              ack_s;
  logic              send_seen_s;
  logic              ack_seen_s;

`ifdef LINK_SYNC_EN
  logic [1:0] send_sync_r;
  logic [1:0] ack_sync_r;

  // Cross each strobe through two flops before the opposite FSM looks at it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      send_sync_r <= 2'b00;
      ack_sync_r  <= 2'b00;
    end else begin
      send_sync_r <= {send_sync_r[0], send_r};
      ack_sync_r  <= {ack_sync_r[0], ack_s};
    end
  end

  assign send_seen_s = send_sync_r[1];
  assign ack_seen_s  = ack_sync_r[1];
`else
  assign send_seen_s = send_r;
  assign ack_seen_s  = ack_s;
`endif

  // CPU next-state; the word advances only once the peripheral has released ack
  always_comb begin
    cpu_state_s = C_PREP;
    dados_s     = dados_r;
    case (cpu_state_r)
      C_PREP: cpu_state_s = C_SEND;
      C_SEND: begin
        if (ack_seen_s) begin
          cpu_state_s = C_WAIT;
        end else begin
          cpu_state_s = C_SEND;
        end
      end
      C_WAIT: begin
        if (!ack_seen_s) begin
          cpu_state_s = C_PREP;
          dados_s     = dados_r + DATA_W'(1);
        end else begin
          cpu_state_s = C_WAIT;
        end
      end
      default: cpu_state_s = C_PREP;
    endcase
  end

  // CPU state, data word and send strobe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_state_r <= C_PREP;
      dados_r     <= {DATA_W{1'b0}};
      send_r      <= 1'b0;
    end else begin
      cpu_state_r <= cpu_state_s;
      dados_r     <= dados_s;
      send_r      <= (cpu_state_s == C_SEND);
    end
  end

  periph_rx #(
    .DATA_W(DATA_W)
  ) u_periph_rx (
    .clk              (clk),
    .rst              (rst),
    .send_in          (send_seen_s),
    .dados_in         (dados_r),
    .ack              (ack_s),
    .estadoPeriferico (estadoPeriferico),
    .dadosPeriferico  (dadosPeriferico)
  );

  assign estadoCPU = cpu_state_r;
  assign dados     = dados_r;
  assign send      = send_r;
  assign ack       = ack_s;

endmodule

// File: tb/tb_cpu_periph_link.sv
// Scoreboard bench for cpu_periph_link: expected captures are queued per run,
// a negedge monitor pops them on each ack rise and checks a per-cycle timeline.
module tb_cpu_periph_link;

  localparam int DW   = 4;
  localparam int M    = 16;
`ifdef LINK_SYNC_EN
  localparam int D    = 2;
`else
  localparam int D    = 0;
`endif
  localparam int P    = 5 + 4 * D;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    estadoCPU;
  logic [1:0]    estadoPeriferico;
  logic [DW-1:0] dados;
  logic          send;
  logic          ack;
  logic [DW-1:0] dadosPeriferico;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  typedef struct {
    int value;
    int edge_no;
  } cap_t;
  cap_t exp_q[$];

  always #HALF clk = ~clk;

  cpu_periph_link #(.DATA_W(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .estadoCPU        (estadoCPU),
    .estadoPeriferico (estadoPeriferico),
    .dados            (dados),
    .send             (send),
    .ack              (ack),
    .dadosPeriferico  (dadosPeriferico)
  );

  // Active edges since the last reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) t <= 0;
    else      t <= t + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // Monitor: timeline model, scoreboard pops on ack rise, continuous invariants
  initial begin
    int p, e_send, e_ack, e_dados, e_cpu, e_dp;
    int ps, pa, pd;
    cap_t c;
    ps = 0; pa = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ps = 0; pa = 0; pd = 0;
      end else begin
        if (t == 0) begin
          e_send = 0; e_ack = 0; e_cpu = 0;
        end else begin
          p      = (t - 1) % P;
          e_send = (p < 2 + 2 * D) ? 1 : 0;
          e_ack  = (p >= 1 + D && p < 3 + 3 * D) ? 1 : 0;
          e_cpu  = (p < 2 + 2 * D) ? 1 : ((p < 4 + 4 * D) ? 2 : 0);
        end
        e_dados = (t / P) % M;
        e_dp    = (t >= 2 + D) ? ((t - 2 - D) / P) % M : 0;
        check("send", int'(send), e_send);
        check("ack", int'(ack), e_ack);
        check("dados", int'(dados), e_dados);
        check("estadoCPU", int'(estadoCPU), e_cpu);
        check("estadoPeriferico", int'(estadoPeriferico), e_ack);
        check("dadosPeriferico", int'(dadosPeriferico), e_dp);

        if (ack && pa == 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL capture_unexpected: got value %0d at edge %0d, required no capture", int'(dadosPeriferico), t);
          end else begin
            c = exp_q.pop_front();
            check("capture_value", int'(dadosPeriferico), c.value);
            check("capture_edge", t, c.edge_no);
          end
        end

        if (ps == 1 || pa == 1) check("dados_stable_in_handshake", int'(dados), pd);
        check("no_dual_toggle", (int'(send) ^ ps) & (int'(ack) ^ pa), 0);
        check("estadoCPU_legal", (estadoCPU == 2'd3) ? 1 : 0, 0);
        check("estadoPeriferico_legal", (estadoPeriferico > 2'd1) ? 1 : 0, 0);

        ps = int'(send); pa = int'(ack); pd = int'(dados);
      end
    end
  end

  // Release reset, run w edges, then assert reset mid-cycle and check it bites at once
  task automatic run(input int w);
    cap_t c;
    for (int k = 0; 2 + D + k * P <= w; k++) begin
      c.value   = k % M;
      c.edge_no = 2 + D + k * P;
      exp_q.push_back(c);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (w) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("rst_send", int'(send), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_dados", int'(dados), 0);
    check("rst_dadosPeriferico", int'(dadosPeriferico), 0);
    check("rst_estadoCPU", int'(estadoCPU), 0);
    check("rst_estadoPeriferico", int'(estadoPeriferico), 0);
    repeat (int'($urandom_range(1, 3))) @(posedge clk);
  endtask

  function automatic int wait_point(input int k);
    return 1 + k * P + (2 + 2 * D) + int'($urandom_range(0, 1 + 2 * D));
  endfunction

  initial begin
    rst = 1'b0;
    #20;
    // 17 captures including the wrap back to 0, reset lands in C_WAIT
    run(wait_point(16));
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) run(wait_point(int'($urandom_range(0, 3))));
      else            run(int'($urandom_range(1, 4 * P)));
    end
    run(2 * P + 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
